// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the write-back stage: instruction codes, register IDs,
// status codes and status FSM states.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam int REG_RSP  = 4;
    localparam int REG_NONE = 15;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

endpackage

// File: rtl/y86_wb_dst_sel.sv
// Combinational destination selection for the W stage: maps icode/rA/rB/cnd to the
// E-port and M-port register IDs (REG_NONE means no write).
module y86_wb_dst_sel
    import y86_pkg::*;
#(
    parameter int W_REG = 4
) (
    input  logic [3:0]       i_icode,
    input  logic [W_REG-1:0] i_ra,
    input  logic [W_REG-1:0] i_rb,
    input  logic             i_cnd,
    output logic [W_REG-1:0] o_dst_e,
    output logic [W_REG-1:0] o_dst_m
);

    localparam logic [W_REG-1:0] W_NONE = W_REG'(REG_NONE);
    localparam logic [W_REG-1:0] W_RSP  = W_REG'(REG_RSP);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        o_dst_e = W_NONE;
        o_dst_m = W_NONE;
        case (i_icode)
            I_RRMOVQ:                       if (i_cnd) o_dst_e = i_rb;
            I_IRMOVQ, I_OPQ:                o_dst_e = i_rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ: o_dst_e = W_RSP;
            default:                        ;
        endcase
        if (i_icode == I_MRMOVQ || i_icode == I_POPQ)
            o_dst_m = i_ra;
    end

endmodule

// File: rtl/y86_writeback_stage.sv
// Y86-64 write-back stage: W pipeline register, register-file write strobes and the
// RUN/HALT status FSM. Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module y86_writeback_stage
    import y86_pkg::*;
#(
    parameter int W_DATA = 64,
    parameter int W_REG  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    input  logic              i_stall,
    input  logic              i_bubble,
    input  logic [3:0]        i_icode,
    input  logic [3:0]        i_ifun,
    input  logic              i_cnd,
    input  logic [W_REG-1:0]  i_ra,
    input  logic [W_REG-1:0]  i_rb,
    input  logic [W_DATA-1:0] i_vale,
    input  logic [W_DATA-1:0] i_valm,
    input  logic [2:0]        i_stat_in,
    output logic              o_we_e,
    output logic [W_REG-1:0]  o_dst_e,
    output logic [W_DATA-1:0] o_wval_e,
    output logic              o_we_m,
    output logic [W_REG-1:0]  o_dst_m,
    output logic [W_DATA-1:0] o_wval_m,
    output logic [2:0]        o_stat,
    output logic              o_halted
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]       o_retired
`endif
);

    localparam logic [W_REG-1:0] W_NONE = W_REG'(REG_NONE);

    logic              r_valid;
    logic              r_fresh;
    logic [3:0]        r_icode;
    logic              r_cnd;
    logic [W_REG-1:0]  r_ra;
    logic [W_REG-1:0]  r_rb;
    logic [W_DATA-1:0] r_vale;
    logic [W_DATA-1:0] r_valm;
    logic [2:0]        r_stat;
    logic [0:0]        r_state;

    logic              w_halted;
    logic              w_fault;
    logic              w_hold;
    logic              w_live;
    logic [W_REG-1:0]  w_dst_e;
    logic [W_REG-1:0]  w_dst_m;
    logic              w_unused_ifun;

    // ifun plays no part in destination selection.
    assign w_unused_ifun = ^i_ifun;

    assign w_halted = (r_state == ST_HALT);
    assign w_fault  = r_valid && (r_stat != STAT_AOK);
    // A faulting instruction stays in W so its status remains visible after the halt.
    assign w_hold   = w_halted || w_fault || i_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_fresh <= 1'b0;
            r_icode <= I_NOP;
            r_cnd   <= 1'b0;
            r_ra    <= W_NONE;
            r_rb    <= W_NONE;
            r_vale  <= '0;
            r_valm  <= '0;
            r_stat  <= STAT_AOK;
            r_state <= ST_RUN;
        end else begin
            // NOTE: non-blocking assignments; the later r_fresh write on a load overrides this default.
            r_fresh <= 1'b0;
            if (w_fault)
                r_state <= ST_HALT;
            if (!w_hold) begin
                if (i_bubble || !i_in_valid) begin
                    r_valid <= 1'b0;
                    r_icode <= I_NOP;
                    r_cnd   <= 1'b0;
                    r_ra    <= W_NONE;
                    r_rb    <= W_NONE;
                    r_vale  <= '0;
                    r_valm  <= '0;
                    r_stat  <= STAT_AOK;
                end else begin
                    r_valid <= 1'b1;
                    r_fresh <= 1'b1;
                    r_icode <= i_icode;
                    r_cnd   <= i_cnd;
                    r_ra    <= i_ra;
                    r_rb    <= i_rb;
                    r_vale  <= i_vale;
                    r_valm  <= i_valm;
                    r_stat  <= i_stat_in;
                end
            end
        end
    end

    y86_wb_dst_sel #(.W_REG(W_REG)) u_dst_sel (
        .i_icode (r_icode),
        .i_ra    (r_ra),
        .i_rb    (r_rb),
        .i_cnd   (r_cnd),
        .o_dst_e (w_dst_e),
        .o_dst_m (w_dst_m)
    );

    assign w_live   = r_valid && r_fresh && (r_stat == STAT_AOK) && !w_halted;
    // popq %rsp: the memory result wins, so the E port stays quiet.
    assign o_we_e   = w_live && (w_dst_e != W_NONE) && (w_dst_e != w_dst_m);
    assign o_we_m   = w_live && (w_dst_m != W_NONE);
    assign o_dst_e  = w_dst_e;
    assign o_dst_m  = w_dst_m;
    assign o_wval_e = r_vale;
    assign o_wval_m = r_valm;
    assign o_stat   = r_valid ? r_stat : STAT_AOK;
    assign o_halted = w_halted;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retired;

    always_ff @(posedge clk) begin
        if (rst)
            r_retired <= '0;
        else if (w_live)
            r_retired <= r_retired + 64'd1;
    end

    assign o_retired = r_retired;
`endif

endmodule
